ccip_eth_csr_mc: RTL
====================

Name: ccip_eth_csr_mc

Overview:
- Multi-channel successor to the single-lane HSSI Ethernet CSR block.
- Decodes CCI-P MMIO reads and writes into an AFU CSR file.
- Bridges indirect Ethernet register commands to one of NUM_CH MAC/PHY Avalon-MM CSR slaves through a single transaction engine with handshake and timeout. This replaces the old edge-detected ctrl_addr scheme.
- Sits between the CCI-P register stage and the per-lane eth_e2e instances.

Parameters:
NUM_CH, 2, number of Ethernet lanes; 1..8
ETH_ADDR_W, 16, Avalon CSR word address width per lane
ETH_DATA_W, 32, Avalon CSR data width; must be ≤ 64
TIMEOUT_CYC, 1024, cycles before an unanswered Avalon access aborts; power of two
AFU_ID_L, 64'hB74F291AF34E1783, AFU GUID low word
AFU_ID_H, 64'h05189FE40676DD24, AFU GUID high word

Ports:
clk  in  1  CCI-P clock
pck_cp2af_softReset_T1  in  1  asynchronous active-high reset
mmio_wr_en  in  1  MMIO write strobe (registered c0 mmioWrValid)
mmio_rd_en  in  1  MMIO read strobe
mmio_addr  in  16  MMIO 4-byte address
mmio_tid  in  9  MMIO transaction ID
mmio_wdata  in  64  MMIO write data
mmio_rsp_v  out  1  c2 mmioRdValid
mmio_rsp_tid  out  9  c2 header tid
mmio_rsp_data  out  64  c2 read data
eth_address  out  NUM_CH*ETH_ADDR_W  per-lane Avalon address
eth_write  out  NUM_CH  per-lane write
eth_read  out  NUM_CH  per-lane read
eth_writedata  out  NUM_CH*ETH_DATA_W  per-lane write data
eth_readdata  in  NUM_CH*ETH_DATA_W  per-lane read data
eth_waitrequest  in  NUM_CH  per-lane waitrequest
eth_readdatavalid  in  NUM_CH  per-lane readdatavalid
init_start  out  NUM_CH  per-lane init request (AFU_INIT bit 2*i)
init_done  in  NUM_CH  per-lane init complete; 2-flop synchronised internally

Behaviour:
- Clock is clk. Reset is pck_cp2af_softReset_T1, asynchronous, active-high. All outputs and registers reset to 0.
- CSR map, 8-byte offsets, decoded on mmio_addr[6:1]:
  - 0x00 DFH: reads 64'h1000000000000001
  - 0x08 ID_L, 0x10 ID_H
  - 0x28 INIT: RW even bits = init_start; RO odd bit 2*i+1 = synced init_done[i]
  - 0x30 CMD: [15:0] addr, [16] wr, [17] rd, [22:20] lane; write-only trigger, readback returns last value
  - 0x38 WDATA: RW
  - 0x40 RDATA: RO
  - 0x48 SCRATCH: RW
  - 0x50 STATUS: [0] busy, [1] done, [2] timeout, [3] illegal, [4] overrun
  - All other offsets read 0; writes to them are ignored.
- MMIO read response:
  - Exactly 2 cycles after mmio_rd_en: mmio_rsp_v=1 for one cycle, with the tid captured at request.
  - Back-to-back reads are fully pipelined, one per cycle.
- CMD write in IDLE:
  - Sets done=0, timeout=0, illegal=0.
  - If wr and rd are both 1, both are 0, or lane ≥ NUM_CH: set illegal, stay IDLE, no Avalon activity.
  - Otherwise go to ISSUE. busy=1.
- FSM IDLE→ISSUE→(WAIT_RD)→IDLE:
  - ISSUE: drive the selected lane's address and write/read (writedata = WDATA[ETH_DATA_W-1:0]). All other lanes stay 0.
  - Hold the request while waitrequest=1.
  - On waitrequest=0: a write goes to IDLE with done=1; a read deasserts read and goes to WAIT_RD.
  - WAIT_RD: on readdatavalid, RDATA = zero-extended readdata, done=1, go to IDLE.
- Timeout:
  - Counter starts at ISSUE entry and counts the ISSUE+WAIT_RD cycles.
  - On reaching TIMEOUT_CYC-1: drop strobes, timeout=1, done=1, RDATA=32'hDEAD_BEEF zero-extended, return to IDLE.
- Overrun:
  - A CMD write while busy is ignored and sets sticky overrun.
  - Writing STATUS with bit4=1 clears overrun; all other STATUS bits are RO.
- A readdatavalid in IDLE (late response after a timeout) is ignored.
- Simultaneous MMIO read of STATUS and FSM completion returns the pre-completion value.
- Reset asserted mid-transaction: strobes drop immediately (asynchronously), FSM returns to IDLE, RDATA=0.

Decomposition:
- Package ccip_eth_csr_pkg:
  - CSR offset localparams
  - CMD/STATUS bit positions
  - t_eth_txn_state enum {IDLE, ISSUE, WAIT_RD}
  - DEADBEEF constant
- Sub-module eth_csr_txn_fsm:
  - Contains the single-lane Avalon transaction engine with timeout counter.
  - Top level does CSR decode, the MMIO response pipeline, and lane mux/demux around the engine.

Test Plan:
- Read offsets 0x00/0x08/0x10 with tids 5/6/7 → rsp_v 2 cycles later, tid 5/6/7, data 64'h1000000000000001/AFU_ID_L/AFU_ID_H.
- Write WDATA=0x1234, CMD={lane1,wr,addr 0x0040}; lane1 waitrequest=1 for 3 cycles → eth_write[1] high 4 cycles, address 0x40, data 0x1234; lane0 idle; STATUS=0x2.
- CMD read lane0 addr 0x0010; readdatavalid 5 cycles after accept with 0xCAFEF00D → RDATA=0x00000000CAFEF00D, STATUS=0x2.
- CMD read lane1 with no response → after 1024 cycles STATUS=0x6, RDATA=0xDEADBEEF; a later readdatavalid leaves RDATA unchanged.
- Illegal CMD (wr=rd=1, then lane=3 with NUM_CH=2) → no eth_write/eth_read activity, STATUS=0x8. Second CMD while busy → STATUS bit4 set; cleared by writing 0x10.
- Assert reset during WAIT_RD → eth_read=0, busy=0, RDATA=0. Write INIT=0x5 → init_start=2'b11; init_done=2'b01 reads back INIT=0x7.

Source files
------------

// File: rtl/ccip_eth_csr_pkg.sv
// Shared definitions for the multi-lane Ethernet CSR block: CSR offsets,
// command/status bit positions, transaction engine states and constants.
package ccip_eth_csr_pkg;

  // CSR offsets as 8-byte word indices (mmio_addr[6:1]).
  localparam logic [5:0] OFF_DFH     = 6'h00;
  localparam logic [5:0] OFF_ID_L    = 6'h01;
  localparam logic [5:0] OFF_ID_H    = 6'h02;
  localparam logic [5:0] OFF_INIT    = 6'h05;
  localparam logic [5:0] OFF_CMD     = 6'h06;
  localparam logic [5:0] OFF_WDATA   = 6'h07;
  localparam logic [5:0] OFF_RDATA   = 6'h08;
  localparam logic [5:0] OFF_SCRATCH = 6'h09;
  localparam logic [5:0] OFF_STATUS  = 6'h0A;

  localparam logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0001;

  // CMD register field positions.
  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_WR_BIT   = 16;
  localparam int CMD_RD_BIT   = 17;
  localparam int CMD_LANE_LSB = 20;

  // STATUS register bit positions.
  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_TIMEOUT  = 2;
  localparam int ST_ILLEGAL  = 3;
  localparam int ST_OVERRUN  = 4;

  // Read data returned when an Avalon access is abandoned.
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } t_eth_txn_state;

  typedef struct packed {
    logic [2:0]  lane;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
  } t_cmd;

  // Pull the command fields out of a raw MMIO write word.
  function automatic t_cmd decode_cmd(input logic [63:0] w);
    t_cmd c;
    c.lane = w[CMD_LANE_LSB +: 3];
    c.rd   = w[CMD_RD_BIT];
    c.wr   = w[CMD_WR_BIT];
    c.addr = w[CMD_ADDR_LSB +: 16];
    return c;
  endfunction

endpackage

// File: rtl/ccip_eth_csr_mc_txn.sv
// Single-lane Avalon-MM transaction engine: issues one read or write,
// honours waitrequest, waits for readdatavalid and aborts on timeout.
module eth_csr_txn_fsm
  import ccip_eth_csr_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              pck_cp2af_softReset_T1,
  input  logic              start,
  input  logic              start_wr,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_wdata,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_write,
  output logic              av_read,
  output logic [DATA_W-1:0] av_writedata,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_waitrequest,
  input  logic              av_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  t_eth_txn_state state_q, state_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_expired;

  assign cnt_expired = (cnt_q == CNT_LAST);

  // State register; the async reset drops the strobes immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) state_q <= IDLE;
    else                        state_q <= state_d;
  end

  // Latch the request at start and count cycles spent outside IDLE.
  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        wr_q    <= start_wr;
        addr_q  <= start_addr;
        wdata_q <= start_wdata;
        cnt_q   <= '0;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next state, Avalon strobes and completion pulses.
  // NOTE: every output of this block gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    av_write  = 1'b0;
    av_read   = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    rd_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        av_write = wr_q;
        av_read  = ~wr_q;
        if (!av_waitrequest) begin
          if (wr_q) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            state_d = WAIT_RD;
          end
        end else if (cnt_expired) begin
          state_d   = IDLE;
          done      = 1'b1;
          timed_out = 1'b1;
        end
      end
      WAIT_RD: begin
        if (av_readdatavalid) begin
          state_d  = IDLE;
          done     = 1'b1;
          rd_valid = 1'b1;
        end else if (cnt_expired) begin
          state_d   = IDLE;
          done      = 1'b1;
          timed_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign av_address   = (state_q == ISSUE) ? addr_q : '0;
  assign av_writedata = av_write ? wdata_q : '0;
  assign rd_data      = av_readdata;

endmodule

// File: rtl/ccip_eth_csr_mc.sv
// CCI-P MMIO CSR file for the multi-lane Ethernet AFU. Decodes MMIO
// accesses, returns read data two cycles later and steers indirect
// Ethernet register commands to one lane through a shared engine.
module ccip_eth_csr_mc
  import ccip_eth_csr_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          ETH_ADDR_W  = 16,
  parameter int          ETH_DATA_W  = 32,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [63:0] AFU_ID_L    = 64'hB74F291AF34E1783,
  parameter logic [63:0] AFU_ID_H    = 64'h05189FE40676DD24
) (
  input  logic                         clk,
  input  logic                         pck_cp2af_softReset_T1,
  input  logic                         mmio_wr_en,
  input  logic                         mmio_rd_en,
  input  logic [15:0]                  mmio_addr,
  input  logic [8:0]                   mmio_tid,
  input  logic [63:0]                  mmio_wdata,
  output logic                         mmio_rsp_v,
  output logic [8:0]                   mmio_rsp_tid,
  output logic [63:0]                  mmio_rsp_data,
  output logic [NUM_CH*ETH_ADDR_W-1:0] eth_address,
  output logic [NUM_CH-1:0]            eth_write,
  output logic [NUM_CH-1:0]            eth_read,
  output logic [NUM_CH*ETH_DATA_W-1:0] eth_writedata,
  input  logic [NUM_CH*ETH_DATA_W-1:0] eth_readdata,
  input  logic [NUM_CH-1:0]            eth_waitrequest,
  input  logic [NUM_CH-1:0]            eth_readdatavalid,
  output logic [NUM_CH-1:0]            init_start,
  input  logic [NUM_CH-1:0]            init_done
);

  logic [5:0] csr_off;
  t_cmd       cmd_f;
  logic       cmd_illegal;
  logic       cmd_wr_hit;
  logic       txn_start;

  logic [NUM_CH-1:0] init_q, done_s1, done_s2;
  logic [63:0] cmd_q, wdata_q, rdata_q, scratch_q;
  logic        done_q, tmo_q, ill_q, ovr_q;
  logic [2:0]  lane_q;

  logic                  txn_busy, txn_done, txn_timed_out, txn_rd_valid;
  logic [ETH_ADDR_W-1:0] e_address;
  logic                  e_write, e_read;
  logic [ETH_DATA_W-1:0] e_writedata, e_readdata, e_rd_data;
  logic                  e_waitrequest, e_readdatavalid;

  logic [63:0] status_v, init_v, rd_mux;
  logic        rsp1_v;
  logic [8:0]  rsp1_tid;
  logic [63:0] rsp1_data;

  // Address bits outside the decoded window are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mmio_addr[15:7], mmio_addr[0]};

  assign csr_off     = mmio_addr[6:1];
  assign cmd_f       = decode_cmd(mmio_wdata);
  assign cmd_illegal = (cmd_f.wr == cmd_f.rd) || (int'(cmd_f.lane) >= NUM_CH);
  assign cmd_wr_hit  = mmio_wr_en && (csr_off == OFF_CMD);
  assign txn_start   = cmd_wr_hit && !txn_busy && !cmd_illegal;

  // Two-flop synchroniser for the per-lane init_done inputs.
  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) begin
      done_s1 <= '0;
      done_s2 <= '0;
    end else begin
      done_s1 <= init_done;
      done_s2 <= done_s1;
    end
  end

  // CSR write decode and status bookkeeping.
  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) begin
      init_q    <= '0;
      cmd_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      scratch_q <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ill_q     <= 1'b0;
      ovr_q     <= 1'b0;
      lane_q    <= '0;
    end else begin
      if (mmio_wr_en) begin
        unique case (csr_off)
          OFF_INIT: begin
            for (int i = 0; i < NUM_CH; i++) init_q[i] <= mmio_wdata[2*i];
          end
          OFF_CMD: begin
            cmd_q <= mmio_wdata;
            if (txn_busy) begin
              ovr_q <= 1'b1;
            end else begin
              done_q <= 1'b0;
              tmo_q  <= 1'b0;
              ill_q  <= cmd_illegal;
            end
          end
          OFF_WDATA:   wdata_q   <= mmio_wdata;
          OFF_SCRATCH: scratch_q <= mmio_wdata;
          OFF_STATUS:  if (mmio_wdata[ST_OVERRUN]) ovr_q <= 1'b0;
          default: ;
        endcase
      end
      if (txn_start)     lane_q  <= cmd_f.lane;
      if (txn_done)      done_q  <= 1'b1;
      if (txn_timed_out) tmo_q   <= 1'b1;
      if (txn_rd_valid)  rdata_q <= 64'(e_rd_data);
      else if (txn_timed_out) rdata_q <= 64'(DEADBEEF);
    end
  end

  // Assemble the composite INIT and STATUS read views.
  always_comb begin
    init_v   = '0;
    status_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      init_v[2*i]   = init_q[i];
      init_v[2*i+1] = done_s2[i];
    end
    status_v[ST_BUSY]    = txn_busy;
    status_v[ST_DONE]    = done_q;
    status_v[ST_TIMEOUT] = tmo_q;
    status_v[ST_ILLEGAL] = ill_q;
    status_v[ST_OVERRUN] = ovr_q;
  end

  // CSR read multiplexer.
  always_comb begin
    rd_mux = '0;
    unique case (csr_off)
      OFF_DFH:     rd_mux = DFH_VALUE;
      OFF_ID_L:    rd_mux = AFU_ID_L;
      OFF_ID_H:    rd_mux = AFU_ID_H;
      OFF_INIT:    rd_mux = init_v;
      OFF_CMD:     rd_mux = cmd_q;
      OFF_WDATA:   rd_mux = wdata_q;
      OFF_RDATA:   rd_mux = rdata_q;
      OFF_SCRATCH: rd_mux = scratch_q;
      OFF_STATUS:  rd_mux = status_v;
      default:     rd_mux = '0;
    endcase
  end

  // Two-stage read response pipeline; one read accepted every cycle.
  // NOTE: the data stages are reset as well so the response bus reads
  // zero out of reset rather than stale contents.
  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) begin
      rsp1_v        <= 1'b0;
      rsp1_tid      <= '0;
      rsp1_data     <= '0;
      mmio_rsp_v    <= 1'b0;
      mmio_rsp_tid  <= '0;
      mmio_rsp_data <= '0;
    end else begin
      rsp1_v        <= mmio_rd_en;
      rsp1_tid      <= mmio_tid;
      rsp1_data     <= rd_mux;
      mmio_rsp_v    <= rsp1_v;
      mmio_rsp_tid  <= rsp1_tid;
      mmio_rsp_data <= rsp1_data;
    end
  end

  // Select the active lane's slave-side inputs.
  always_comb begin
    e_waitrequest   = 1'b0;
    e_readdatavalid = 1'b0;
    e_readdata      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lane_q == 3'(i)) begin
        e_waitrequest   = eth_waitrequest[i];
        e_readdatavalid = eth_readdatavalid[i];
        e_readdata      = eth_readdata[i*ETH_DATA_W +: ETH_DATA_W];
      end
    end
  end

  // Route the engine's request onto the active lane; others stay 0.
  always_comb begin
    eth_address   = '0;
    eth_write     = '0;
    eth_read      = '0;
    eth_writedata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lane_q == 3'(i)) begin
        eth_address[i*ETH_ADDR_W +: ETH_ADDR_W]   = e_address;
        eth_write[i]                              = e_write;
        eth_read[i]                               = e_read;
        eth_writedata[i*ETH_DATA_W +: ETH_DATA_W] = e_writedata;
      end
    end
  end

  assign init_start = init_q;

  eth_csr_txn_fsm #(
    .ADDR_W      (ETH_ADDR_W),
    .DATA_W      (ETH_DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_txn (
    .clk                    (clk),
    .pck_cp2af_softReset_T1 (pck_cp2af_softReset_T1),
    .start                  (txn_start),
    .start_wr               (cmd_f.wr),
    .start_addr             (ETH_ADDR_W'(cmd_f.addr)),
    .start_wdata            (wdata_q[ETH_DATA_W-1:0]),
    .av_address             (e_address),
    .av_write               (e_write),
    .av_read                (e_read),
    .av_writedata           (e_writedata),
    .av_readdata            (e_readdata),
    .av_waitrequest         (e_waitrequest),
    .av_readdatavalid       (e_readdatavalid),
    .busy                   (txn_busy),
    .done                   (txn_done),
    .timed_out              (txn_timed_out),
    .rd_valid               (txn_rd_valid),
    .rd_data                (e_rd_data)
  );

endmodule
